// File: rtl/calc_core_if.sv
// ----------------------------------------------------------------------------
// calc_core_if
// Bundles the operand/result handshake of calc_core.
//   in_valid / in_ready   : operand-set handshake (x, y, sel)
//   x, y                  : WIDTH-bit operands (signed; y unsigned for EXP)
//   sel                   : 0 ADD, 1 SUB, 2 MUL, 3 EXP
//   out_valid / out_ready : result handshake (result, ovf, zero)
// Modports: master = producer/consumer side, slave = calc_core side.
// ----------------------------------------------------------------------------
interface calc_core_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [1:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, x, y, sel, out_ready,
        input  in_ready, out_valid, result, ovf, zero
    );

    modport slave (
        input  in_valid, x, y, sel, out_ready,
        output in_ready, out_valid, result, ovf, zero
    );
endinterface

// File: rtl/calc_core.sv
// ----------------------------------------------------------------------------
// calc_core
// Small signed arithmetic unit with a valid/ready handshake on both sides.
// ADD, SUB and EXP complete in one cycle; MUL runs a radix-2 Booth engine
// that retires one multiplier bit per cycle (WIDTH cycles). One operation is
// in flight at a time; the result is held until the consumer takes it.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : calc_core_if.slave (operands, sel, result, ovf, zero, handshakes)
// ----------------------------------------------------------------------------
module calc_core #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    calc_core_if.slave   bus
);
    localparam int MSB   = WIDTH - 1;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DONE     = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_EXP = 2'd3
    } op_t;

    state_t           state;
    op_t              op;

    // Booth engine: acc carries one guard bit so that subtracting the most
    // negative multiplicand cannot wrap.
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] mq;      // multiplier, shifts out as low product half
    logic             q_m1;    // Booth look-behind bit
    logic [WIDTH-1:0] mcand;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] result_q;
    logic             ovf_q;
    logic             zero_q;
    logic             out_valid_q;

    // Single-cycle datapath, computed from the live inputs and captured at
    // the transfer edge.
    logic [WIDTH-1:0] add_res;
    logic             add_ovf;
    logic [WIDTH-1:0] sub_res;
    logic             sub_ovf;
    logic [31:0]      exp_n;
    logic [WIDTH-1:0] exp_res;
    logic             exp_ovf;
    logic [WIDTH-1:0] fast_res;
    logic             fast_ovf;

    // Booth step
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   nxt_acc;
    logic [WIDTH-1:0] nxt_mq;
    logic [WIDTH:0]   prod_top;  // product bits [2W-1 : W-1]
    logic             mul_ovf;

    assign op = op_t'(bus.sel);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        add_res  = bus.x + bus.y;
        add_ovf  = (bus.x[MSB] == bus.y[MSB]) && (add_res[MSB] != bus.x[MSB]);

        sub_res  = bus.x - bus.y;
        sub_ovf  = (bus.x[MSB] != bus.y[MSB]) && (sub_res[MSB] != bus.x[MSB]);

        exp_n    = 32'(bus.y);
        exp_res  = '0;
        if (exp_n < 32'(WIDTH)) begin
            exp_res = ONE << bus.y;
        end
        // 1<<(WIDTH-1) is the sign bit, so it is already out of range.
        exp_ovf  = (exp_n >= 32'(WIDTH - 1));

        fast_res = add_res;
        fast_ovf = add_ovf;
        case (op)
            OP_SUB: begin
                fast_res = sub_res;
                fast_ovf = sub_ovf;
            end
            OP_EXP: begin
                fast_res = exp_res;
                fast_ovf = exp_ovf;
            end
            default: begin
                fast_res = add_res;
                fast_ovf = add_ovf;
            end
        endcase

        m_ext     = {mcand[MSB], mcand};
        booth_sum = acc;
        case ({mq[0], q_m1})
            2'b01:   booth_sum = acc + m_ext;
            2'b10:   booth_sum = acc - m_ext;
            default: booth_sum = acc;
        endcase
        // Arithmetic shift right of {acc, mq}.
        nxt_acc  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        nxt_mq   = {booth_sum[0], mq[WIDTH-1:1]};
        prod_top = {nxt_acc[WIDTH-1:0], nxt_mq[MSB]};
        mul_ovf  = !((&prod_top) || (~|prod_top));
    end

    // NOTE: all state uses non-blocking assignments so every register sees
    // the pre-edge values of the others, independent of statement order.
    // NOTE: every register, including the multiplier datapath, is reset so
    // an aborted multiply leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            mq          <= '0;
            q_m1        <= 1'b0;
            mcand       <= '0;
            cnt         <= '0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (op == OP_MUL) begin
                            mcand <= bus.x;
                            mq    <= bus.y;
                            acc   <= '0;
                            q_m1  <= 1'b0;
                            cnt   <= '0;
                            state <= MUL_BUSY;
                        end else begin
                            result_q    <= fast_res;
                            ovf_q       <= fast_ovf;
                            zero_q      <= (fast_res == '0);
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end

                MUL_BUSY: begin
                    acc  <= nxt_acc;
                    mq   <= nxt_mq;
                    q_m1 <= mq[0];
                    cnt  <= cnt + 1'b1;
                    // The last bit is retired on the WIDTH-th edge after the
                    // transfer; the result is taken straight from the step.
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        result_q    <= nxt_mq;
                        ovf_q       <= mul_ovf;
                        zero_q      <= (nxt_mq == '0);
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end

                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // in_ready is gated by rst directly so it drops the moment reset rises
    // and is up in the first cycle after reset releases.
    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_calc_core.sv
// ----------------------------------------------------------------------------
// tb_calc_core
// Directed bench for calc_core at WIDTH=8 and WIDTH=16. Both instances share
// clk and rst; one is exercised at a time while the other sits idle.
// ----------------------------------------------------------------------------
module tb_calc_core;
    localparam logic [1:0] ADD = 2'd0;
    localparam logic [1:0] SUB = 2'd1;
    localparam logic [1:0] MUL = 2'd2;
    localparam logic [1:0] EXP = 2'd3;

    logic clk;
    logic rst;

    int total = 0;
    int bad   = 0;

    calc_core_if #(.WIDTH(8))  b8  ();
    calc_core_if #(.WIDTH(16)) b16 ();

    calc_core #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8.slave));
    calc_core #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        in_ready;
        logic        out_valid;
        logic        ovf;
        logic        zero;
        logic [31:0] result;
    } obs_t;

    function automatic obs_t sample(input bit w16);
        obs_t o;
        if (w16) begin
            o = '{b16.in_ready, b16.out_valid, b16.ovf, b16.zero, 32'(b16.result)};
        end else begin
            o = '{b8.in_ready, b8.out_valid, b8.ovf, b8.zero, 32'(b8.result)};
        end
        return o;
    endfunction

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit w16, input logic iv, input logic ordy,
                         input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
        if (w16) begin
            b16.in_valid = iv; b16.out_ready = ordy; b16.sel = s;
            b16.x = a[15:0];   b16.y = b[15:0];
        end else begin
            b8.in_valid = iv;  b8.out_ready = ordy;  b8.sel = s;
            b8.x = a[7:0];     b8.y = b[7:0];
        end
    endtask

    // Issue one operation and wait for its result. exp_lat counts falling
    // edges from the transfer edge to the first one that shows out_valid.
    task automatic run_op(input string tag, input bit w16, input logic [1:0] s,
                          input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                          input logic [31:0] exp_res, input logic exp_ovf, input logic exp_zero);
        obs_t o;
        int   lat;
        bit   got;
        bit   overlap;
        bit   early_rdy;
        @(negedge clk);
        drive(w16, 1'b1, 1'b0, s, a, b);
        o = sample(w16);
        check({tag, ":in_ready"}, 36'(o.in_ready), 36'(1));
        @(posedge clk);
        @(negedge clk);
        // Scramble the inputs right after the transfer; the operation must
        // already have captured them.
        drive(w16, 1'b0, 1'b0, ~s, ~a, ~b);
        lat = 0; got = 1'b0; overlap = 1'b0; early_rdy = 1'b0;
        while (!got && lat < 64) begin
            if (lat != 0) @(negedge clk);
            lat++;
            o = sample(w16);
            if (o.in_ready && o.out_valid) overlap = 1'b1;
            if (o.in_ready && !o.out_valid) early_rdy = 1'b1;
            got = o.out_valid;
        end
        check({tag, ":latency"}, 36'(lat), 36'(exp_lat));
        check({tag, ":busy"}, 36'({overlap, early_rdy}), 36'(0));
        check({tag, ":out"}, 36'(o), {1'b0, 1'b1, exp_ovf, exp_zero, exp_res});
    endtask

    task automatic consume(input string tag, input bit w16);
        obs_t o;
        drive(w16, 1'b0, 1'b1, ADD, 32'd0, 32'd0);
        @(negedge clk);
        o = sample(w16);
        check({tag, ":back_idle"}, 36'({o.out_valid, o.in_ready}), 36'(2'b01));
        drive(w16, 1'b0, 1'b0, ADD, 32'd0, 32'd0);
    endtask

    // Start a multiply, pulse reset three cycles in, confirm the abort, then
    // show the block is usable again.
    task automatic reset_abort(input string tag, input bit w16);
        obs_t o;
        bit   pulse;
        @(negedge clk);
        drive(w16, 1'b1, 1'b0, MUL, 32'd5, 32'd5);
        @(posedge clk);
        @(negedge clk);
        drive(w16, 1'b0, 1'b0, ADD, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        o = sample(w16);
        check({tag, ":rst_now"}, 36'(o), 36'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        o = sample(w16);
        check({tag, ":after_rst"}, 36'(o), {1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
        pulse = 1'b0;
        repeat (20) begin
            @(negedge clk);
            o = sample(w16);
            if (o.out_valid) pulse = 1'b1;
        end
        check({tag, ":no_pulse"}, 36'(pulse), 36'(0));
        run_op({tag, ":add_1_1"}, w16, ADD, 32'd1, 32'd1, 1, 32'h2, 1'b0, 1'b0);
        consume({tag, ":add_1_1"}, w16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        obs_t held;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, ADD, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, ADD, 32'd0, 32'd0);
        #1;
        check("rst8", 36'(sample(1'b0)), 36'(0));
        check("rst16", 36'(sample(1'b1)), 36'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel8", 36'(sample(1'b0)), {1'b1, 1'b0, 1'b0, 1'b0, 32'd0});

        // ---------------- WIDTH = 8 ----------------
        run_op("add_100_50", 1'b0, ADD, 32'd100, 32'd50, 1, 32'h96, 1'b1, 1'b0);
        consume("add_100_50", 1'b0);
        run_op("add_m1_1", 1'b0, ADD, 32'hFFFF_FFFF, 32'd1, 1, 32'h00, 1'b0, 1'b1);
        consume("add_m1_1", 1'b0);
        run_op("sub_5_7", 1'b0, SUB, 32'd5, 32'd7, 1, 32'hFE, 1'b0, 1'b0);
        consume("sub_5_7", 1'b0);
        run_op("sub_0_m128", 1'b0, SUB, 32'd0, 32'hFFFF_FF80, 1, 32'h80, 1'b1, 1'b0);
        consume("sub_0_m128", 1'b0);
        run_op("mul_m3_7", 1'b0, MUL, 32'hFFFF_FFFD, 32'd7, 9, 32'hEB, 1'b0, 1'b0);
        consume("mul_m3_7", 1'b0);
        run_op("mul_16_16", 1'b0, MUL, 32'd16, 32'd16, 9, 32'h00, 1'b1, 1'b1);
        consume("mul_16_16", 1'b0);
        run_op("mul_m128_m128", 1'b0, MUL, 32'hFFFF_FF80, 32'hFFFF_FF80, 9, 32'h00, 1'b1, 1'b1);
        consume("mul_m128_m128", 1'b0);
        run_op("mul_m128_1", 1'b0, MUL, 32'hFFFF_FF80, 32'd1, 9, 32'h80, 1'b0, 1'b0);
        consume("mul_m128_1", 1'b0);
        run_op("exp_3", 1'b0, EXP, 32'd0, 32'd3, 1, 32'h08, 1'b0, 1'b0);
        consume("exp_3", 1'b0);
        run_op("exp_6", 1'b0, EXP, 32'd0, 32'd6, 1, 32'h40, 1'b0, 1'b0);
        consume("exp_6", 1'b0);
        run_op("exp_7", 1'b0, EXP, 32'd0, 32'd7, 1, 32'h80, 1'b1, 1'b0);
        consume("exp_7", 1'b0);
        run_op("exp_9", 1'b0, EXP, 32'd0, 32'd9, 1, 32'h00, 1'b1, 1'b1);
        consume("exp_9", 1'b0);

        // Hold: result stays put while the consumer stalls and inputs churn.
        run_op("hold_add", 1'b0, ADD, 32'd7, 32'd8, 1, 32'h0F, 1'b0, 1'b0);
        held = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0F};
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 2'(i), $urandom, $urandom);
            @(negedge clk);
            o = sample(1'b0);
            check($sformatf("hold_cyc%0d", i), 36'(o), 36'(held));
        end
        consume("hold_add", 1'b0);

        reset_abort("abort8", 1'b0);

        // ---------------- WIDTH = 16 ----------------
        run_op("w16_add_100_50", 1'b1, ADD, 32'd100, 32'd50, 1, 32'h0096, 1'b0, 1'b0);
        consume("w16_add_100_50", 1'b1);
        run_op("w16_add_max_1", 1'b1, ADD, 32'h7FFF, 32'd1, 1, 32'h8000, 1'b1, 1'b0);
        consume("w16_add_max_1", 1'b1);
        run_op("w16_sub_0_min", 1'b1, SUB, 32'd0, 32'h8000, 1, 32'h8000, 1'b1, 1'b0);
        consume("w16_sub_0_min", 1'b1);
        run_op("w16_mul_300_m200", 1'b1, MUL, 32'd300, 32'hFFFF_FF38, 17, 32'h15A0, 1'b1, 1'b0);
        consume("w16_mul_300_m200", 1'b1);
        run_op("w16_mul_m3_7", 1'b1, MUL, 32'hFFFF_FFFD, 32'd7, 17, 32'hFFEB, 1'b0, 1'b0);
        consume("w16_mul_m3_7", 1'b1);
        run_op("w16_exp_14", 1'b1, EXP, 32'd0, 32'd14, 1, 32'h4000, 1'b0, 1'b0);
        consume("w16_exp_14", 1'b1);
        run_op("w16_exp_15", 1'b1, EXP, 32'd0, 32'd15, 1, 32'h8000, 1'b1, 1'b0);
        consume("w16_exp_15", 1'b1);
        run_op("w16_exp_16", 1'b1, EXP, 32'd0, 32'd16, 1, 32'h0000, 1'b1, 1'b1);
        consume("w16_exp_16", 1'b1);

        reset_abort("abort16", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/calc_core.md
CALC_CORE -- requirements
Module: calc_core

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be supported for 4..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operand set presented.
REQ-005 in_ready  output  1  block accepts an operand set this cycle.
REQ-006 x  input  WIDTH  signed two's-complement operand A.
REQ-007 y  input  WIDTH  signed operand B; unsigned shift amount in EXP.
REQ-008 sel  input  2  operation: 0 ADD, 1 SUB, 2 MUL, 3 EXP.
REQ-009 out_valid  output  1  result, ovf and zero valid.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 result  output  WIDTH  signed result, truncated to WIDTH bits.
REQ-012 ovf  output  1  result not representable in WIDTH signed bits.
REQ-013 zero  output  1  result equals 0.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, MUL_BUSY, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE with rst low; a transfer occurs on a rising edge with in_valid and in_ready both 1.
REQ-016 x, y and sel SHALL be captured at the transfer edge; later input changes SHALL NOT affect the operation in flight.
REQ-017 ADD, SUB, EXP: IDLE->DONE at the transfer edge; out_valid SHALL be 1 in the cycle after the transfer (latency 1).
REQ-018 MUL: IDLE->MUL_BUSY at the transfer edge; an iterative shift-add/radix-2 Booth engine SHALL process one multiplier bit per cycle; MUL_BUSY->DONE exactly WIDTH edges after the transfer edge.
REQ-019 DONE: out_valid=1; result/ovf/zero SHALL be held stable until an edge with out_ready=1, which moves DONE->IDLE.
REQ-020 No new transfer SHALL be accepted in MUL_BUSY or DONE (one operation in flight).
REQ-021 ADD: result=(x+y) mod 2^WIDTH; ovf=1 when x, y share a sign and the result sign differs.
REQ-022 SUB: result=(x-y) mod 2^WIDTH; ovf=1 when x, y differ in sign and the result sign differs from x; y=most-negative SHALL be handled correctly.
REQ-023 MUL: result=low WIDTH bits of the full 2*WIDTH-bit signed product; ovf=1 when the upper WIDTH+1 product bits are not all equal.
REQ-024 EXP: y as unsigned n; result=1<<n for n<WIDTH, 0 otherwise; ovf=1 when n>=WIDTH-1.
REQ-025 zero SHALL be 1 exactly when result==0, regardless of ovf.
REQ-026 out_valid and in_ready SHALL never both be 1 in the same cycle.

Reset
REQ-027 rst high SHALL immediately force state IDLE, out_valid=0, in_ready=0, result=0, ovf=0, zero=0, and clear the multiplier accumulator and bit counter.
REQ-028 rst asserted during MUL_BUSY or DONE SHALL abort the operation with no out_valid pulse; in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-029 WIDTH=8, ADD x=100 y=50 -> one cycle later out_valid=1, result=0x96, ovf=1, zero=0.
REQ-030 WIDTH=8, SUB x=5 y=7 -> result=0xFE, ovf=0; SUB x=0 y=-128 -> result=0x80, ovf=1.
REQ-031 WIDTH=8, MUL x=-3 y=7 -> in_ready=0 for 8 cycles, out_valid 8 edges after transfer, result=0xEB, ovf=0; MUL 16*16 -> result=0x00, ovf=1, zero=1.
REQ-032 WIDTH=8, EXP y=3 -> result=0x08, ovf=0; y=7 -> 0x80, ovf=1; y=9 -> 0x00, ovf=1, zero=1.
REQ-033 out_ready held 0 for 5 cycles after out_valid with x/y/sel toggling -> result/flags constant, in_ready=0; out_ready=1 -> IDLE next edge.
REQ-034 rst pulsed 3 cycles into a MUL -> all outputs 0 at once, no out_valid; following ADD 1+1 -> result=0x02; repeat all at WIDTH=16 with MUL 300*-200 -> 0x15A0, ovf=1.
